// File: rtl/entropy_src_ht_fail_monitor.sv
// entropy_src_ht_fail_monitor
//
// Health-test failure monitor. It sits behind one health test, such as the
// repetition count test, and watches that test's fail pulse and test count.
// It tracks the highest test count seen and counts failures per sample
// window and in total. When the failures in one window reach a programmed
// threshold, it raises a one-cycle alert pulse and sets a sticky alert.
// Its outputs feed the entropy_src alert/status registers.
//
// Ports
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   active_i           monitor enable; low forces IDLE and clears all state
//   clear_i            synchronous clear of counters, watermark and sticky alert
//   sample_vld_i       one pulse per entropy sample consumed by the health test
//   test_cnt_i         current test count from the health test
//   test_fail_pulse_i  single-cycle fail pulse from the health test
//   window_size_i      samples per window; 0 = window never closes
//   alert_thresh_i     window failures that raise an alert; 0 = alerts disabled
//   watermark_o        maximum test_cnt_i since last clear
//   win_fail_cnt_o     failures in the current window (saturating)
//   total_fail_cnt_o   failures since last clear (saturating)
//   win_done_pulse_o   one-cycle pulse when a window closes
//   alert_pulse_o      one-cycle pulse when window failures reach the threshold
//   alert_o            sticky alert
//   cnt_err_o          internal counter consistency error (sticky)
//
// FSM states
//   state | meaning
//   IDLE  | monitor disabled, all state held at zero
//   RUN   | counting samples and failures, tracking the watermark

module entropy_src_ht_fail_monitor #(
  parameter int RegWidth     = 16,
  parameter int FailCntWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    active_i,
  input  logic                    clear_i,
  input  logic                    sample_vld_i,
  input  logic [RegWidth-1:0]     test_cnt_i,
  input  logic                    test_fail_pulse_i,
  input  logic [RegWidth-1:0]     window_size_i,
  input  logic [FailCntWidth-1:0] alert_thresh_i,
  output logic [RegWidth-1:0]     watermark_o,
  output logic [FailCntWidth-1:0] win_fail_cnt_o,
  output logic [FailCntWidth-1:0] total_fail_cnt_o,
  output logic                    win_done_pulse_o,
  output logic                    alert_pulse_o,
  output logic                    alert_o,
  output logic                    cnt_err_o
);

  localparam logic [RegWidth-1:0]     REG_ONE  = {{(RegWidth-1){1'b0}}, 1'b1};
  localparam logic [FailCntWidth-1:0] FAIL_ONE = {{(FailCntWidth-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_n;
  logic [RegWidth-1:0]     watermark_q, watermark_n;
  logic [RegWidth-1:0]     sample_cnt_q, sample_cnt_n;
  logic [RegWidth-1:0]     win_size_q, win_size_n;
  logic                    resized_q, resized_n;
  logic [FailCntWidth-1:0] win_fail_q, win_fail_n;
  logic [FailCntWidth-1:0] total_fail_q, total_fail_n;
  logic                    win_done_q, win_done_n;
  logic                    alert_pulse_q, alert_pulse_n;
  logic                    alert_q, alert_n;
  logic                    fired_q, fired_n;
  logic                    cnt_err_q, cnt_err_n;

  logic win_close;
  logic alert_hit;
  logic err_cond;

  // Consistency check on registered state only. The check on the sample count
  // is suppressed while a window runs under a window size that was changed
  // mid-window. In that case the count can legally exceed the new limit until
  // the next sample closes the window.
  always_comb begin
    err_cond = 1'b0;
    if ((win_fail_q > total_fail_q) && (total_fail_q != '1)) begin
      err_cond = 1'b1;
    end
    if ((win_size_q != '0) && (sample_cnt_q > (win_size_q - REG_ONE)) && !resized_q) begin
      err_cond = 1'b1;
    end
  end

  always_comb begin
    state_n       = state_q;
    watermark_n   = '0;
    sample_cnt_n  = '0;
    resized_n     = 1'b0;
    win_fail_n    = '0;
    total_fail_n  = '0;
    win_done_n    = 1'b0;
    alert_pulse_n = 1'b0;
    alert_n       = 1'b0;
    fired_n       = 1'b0;
    cnt_err_n     = 1'b0;
    win_close     = 1'b0;
    alert_hit     = 1'b0;
    // Shadow of the window size, used only to detect mid-window changes.
    win_size_n    = window_size_i;

    case (state_q)
      IDLE: begin
        if (active_i && !clear_i) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (!active_i) begin
          state_n = IDLE;
        end else if (!clear_i) begin
          watermark_n = (test_cnt_i > watermark_q) ? test_cnt_i : watermark_q;

          // The comparison uses >= so that a window shrunk below the current
          // count still closes on the next sample.
          win_close = sample_vld_i && (window_size_i != '0) &&
                      (sample_cnt_q >= (window_size_i - REG_ONE));

          if (win_close) begin
            sample_cnt_n = '0;
          end else if (sample_vld_i && (sample_cnt_q != '1)) begin
            sample_cnt_n = sample_cnt_q + REG_ONE;
          end else begin
            sample_cnt_n = sample_cnt_q;
          end

          if (win_close) begin
            resized_n = 1'b0;
          end else begin
            resized_n = resized_q ||
                        ((window_size_i != win_size_q) && (sample_cnt_q != '0));
          end

          // A fail coinciding with the window close belongs to the new window.
          if (win_close) begin
            win_fail_n = test_fail_pulse_i ? FAIL_ONE : '0;
          end else if (test_fail_pulse_i && (win_fail_q != '1)) begin
            win_fail_n = win_fail_q + FAIL_ONE;
          end else begin
            win_fail_n = win_fail_q;
          end

          if (test_fail_pulse_i && (total_fail_q != '1)) begin
            total_fail_n = total_fail_q + FAIL_ONE;
          end else begin
            total_fail_n = total_fail_q;
          end

          // The alert fires only when a fail moves the count to or past the
          // threshold, and only once per window. A window close re-arms it.
          alert_hit = (alert_thresh_i != '0) && test_fail_pulse_i &&
                      (win_fail_n >= alert_thresh_i) && (win_close || !fired_q);

          fired_n       = win_close ? alert_hit : (fired_q || alert_hit);
          win_done_n    = win_close;
          alert_pulse_n = alert_hit;
          alert_n       = alert_q || alert_hit;
          cnt_err_n     = cnt_err_q || err_cond;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      watermark_q   <= '0;
      sample_cnt_q  <= '0;
      win_size_q    <= '0;
      resized_q     <= 1'b0;
      win_fail_q    <= '0;
      total_fail_q  <= '0;
      win_done_q    <= 1'b0;
      alert_pulse_q <= 1'b0;
      alert_q       <= 1'b0;
      fired_q       <= 1'b0;
      cnt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_n;
      watermark_q   <= watermark_n;
      sample_cnt_q  <= sample_cnt_n;
      win_size_q    <= win_size_n;
      resized_q     <= resized_n;
      win_fail_q    <= win_fail_n;
      total_fail_q  <= total_fail_n;
      win_done_q    <= win_done_n;
      alert_pulse_q <= alert_pulse_n;
      alert_q       <= alert_n;
      fired_q       <= fired_n;
      cnt_err_q     <= cnt_err_n;
    end
  end

  assign watermark_o      = watermark_q;
  assign win_fail_cnt_o   = win_fail_q;
  assign total_fail_cnt_o = total_fail_q;
  assign win_done_pulse_o = win_done_q;
  assign alert_pulse_o    = alert_pulse_q;
  assign alert_o          = alert_q;
  assign cnt_err_o        = cnt_err_q;

endmodule
